axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-requester AXI read-channel arbiter placing the instruction cache (requester 0) and data cache (requester 1) on the single top-level AXI read port. Grants are round-robin and locked per burst: the AR handshake and every R beat through `rlast` belong to one requester. Upstream caches drive AR/R signals exactly as they would a bare port. The arbiter checks beat count against `arlen`.
## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; `m_axi_arsize` = log2(DATA_W/8)
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- s_arvalid  input  [1:0]  per-requester read-address valid
- s_arready  output  [1:0]  per-requester read-address ready
- s_araddr  input  [1:0][ADDR_W-1:0]  per-requester address
- s_arlen  input  [1:0][7:0]  per-requester burst length (beats−1)
- s_rvalid  output  [1:0]  per-requester read-data valid
- s_rready  input  [1:0]  per-requester read-data ready
- s_rdata  output  DATA_W  read data, broadcast to both
- s_rlast  output  1  last beat, broadcast; qualified by `s_rvalid`
- m_axi_arvalid  output  1  downstream address valid
- m_axi_arready  input  1  downstream address ready
- m_axi_araddr  output  ADDR_W  downstream address
- m_axi_arlen  output  8  downstream burst length
- m_axi_arsize  output  3  constant log2(DATA_W/8) (3'b011 at default)
- m_axi_arburst  output  2  constant 2'b10 (WRAP)
- m_axi_rvalid  input  1  downstream data valid
- m_axi_rready  output  1  downstream data ready
- m_axi_rdata  input  DATA_W  downstream data
- m_axi_rlast  input  1  downstream last beat
- grant_idx  output  1  current/last granted requester
- len_err  output  1  one-cycle pulse on burst length mismatch
## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: all `s_arready`, `s_rvalid`, `m_axi_arvalid`, `m_axi_rready` are 0. If any `s_arvalid` is set, pick a winner. With a single requester, that requester wins. With both, the requester ≠ `last_grant` wins. On the winning edge, register `grant_idx` and `lat_len = s_arlen[grant]`, clear `beat_cnt`, then go to ADDR.
- ADDR: `m_axi_arvalid` = `s_arvalid[g]`, `m_axi_araddr`/`m_axi_arlen` come from requester g, and `s_arready[g]` = `m_axi_arready`. The other requester's `s_arready` = 0. On the `m_axi_arvalid && m_axi_arready` edge, go to DATA.
- DATA: `s_rvalid[g]` = `m_axi_rvalid` and `m_axi_rready` = `s_rready[g]`; the non-granted `s_rvalid` = 0. Each beat handshake increments `beat_cnt` (8-bit). On a handshake with `m_axi_rlast`, set `last_grant` = g and go to IDLE.
- `len_err`: pulses if `rlast` arrives while `beat_cnt != lat_len`, or if a beat with `beat_cnt == lat_len` lacks `rlast`. It is reported only and does not change FSM flow.
- A requester dropping `s_arvalid` in ADDR is a protocol violation; the arbiter simply forwards the dropped valid.
- New requests arriving during ADDR/DATA wait, with `s_arready` held 0.
## Timing
- Reset (`reset`=0, async): state=IDLE, `last_grant`=1 (requester 0 wins first tie), `grant_idx`=0, `beat_cnt`=0, `len_err`=0. All valid/ready outputs are 0 and `m_axi_araddr`/`arlen` are 0. Reset asserted mid-burst aborts immediately.
- Arbitration latency is 1 cycle: a request sampled in IDLE at edge N gives `m_axi_arvalid` high in cycle N+1. The AR path is combinational from `s_ar*`/`m_axi_arready` while in ADDR.
- R path is combinational passthrough with zero added latency; throughput is 1 beat/cycle.
- Back-to-back bursts: after the `rlast` edge there is 1 IDLE cycle before the next grant, giving a minimum 2-cycle gap between `rlast` and the next `m_axi_arvalid`.
- `arlen`=0 (single beat) is legal; `rlast` is expected on beat 0.
## Structure
- Package `axi_arb_pkg`: `arb_state_t` enum {IDLE, ADDR, DATA}, `REQ_ICACHE`=0, `REQ_DCACHE`=1, `AXI_BURST_WRAP`=2'b10.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker (req[1:0], last → winner). Everything else is in the top.
## Test plan
- Single request: requester 0 asks for 0x8000_0040 with `arlen`=7; slave `arready` is delayed 3 cycles and returns 8 beats → exactly one AR reaches downstream, `s_rvalid[0]` pulses 8 times, `s_rvalid[1]` stays 0 and `len_err` stays 0.
- Simultaneous requests after reset (0x1000 and 0x2000, both `arlen`=7) → requester 0 goes first; requester 1's AR appears 2 cycles after the first `rlast`.
- Alternation: both requesters continuously requesting, 4 bursts → grant order 0,1,0,1.
- Backpressure: `s_rready[1]` toggles every other cycle during a 4-beat burst → `m_axi_rready` mirrors it, all 4 beats are delivered, and no data is lost.
- Length error: `arlen`=3 but the slave asserts `rlast` on beat 1 → `len_err` pulses once and the FSM returns to IDLE; also `arlen`=1 with no `rlast` on beat 1 → one `len_err` pulse.
- Reset mid-DATA at beat 2 of 8 → all outputs are 0 asynchronously; after release, requester 0 wins the next tie.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
// Holds the FSM state encoding, requester indices and fixed AXI burst attributes.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time. Zero latency, no backpressure of its own.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       winner
);

  always_comb begin
    any    = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI read arbiter for icache/dcache; one grant holds AR plus all R beats to rlast.
// Latency: 1 cycle to grant, AR and R paths combinational passthrough; stalls follow the granted side.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             s_arvalid,
  output logic [1:0]             s_arready,
  input  logic [1:0][ADDR_W-1:0] s_araddr,
  input  logic [1:0][7:0]        s_arlen,
  output logic [1:0]             s_rvalid,
  input  logic [1:0]             s_rready,
  output logic [DATA_W-1:0]      s_rdata,
  output logic                   s_rlast,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  output logic [ADDR_W-1:0]      m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  input  logic [DATA_W-1:0]      m_axi_rdata,
  input  logic                   m_axi_rlast,
  output logic                   grant_idx,
  output logic                   len_err
);

  localparam logic [2:0] AR_SIZE = axi_size(DATA_W);

  arb_state_t state_q, state_d;
  logic       grant_q;
  logic       last_grant_q;
  logic [7:0] lat_len_q;
  logic [7:0] beat_cnt_q;
  logic       len_err_q;
  logic       pick_any;
  logic       pick_win;
  logic       r_hs;

  rr_pick2 u_pick (
    .req    (s_arvalid),
    .last   (last_grant_q),
    .any    (pick_any),
    .winner (pick_win)
  );

  assign r_hs = (state_q == DATA) && m_axi_rvalid && s_rready[grant_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    s_arready     = 2'b00;
    s_rvalid      = 2'b00;
    s_rdata       = '0;
    s_rlast       = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = ADDR;
      end
      ADDR: begin
        m_axi_arvalid      = s_arvalid[grant_q];
        m_axi_araddr       = s_araddr[grant_q];
        m_axi_arlen        = s_arlen[grant_q];
        s_arready[grant_q] = m_axi_arready;
        if (s_arvalid[grant_q] && m_axi_arready) state_d = DATA;
      end
      DATA: begin
        s_rvalid[grant_q] = m_axi_rvalid;
        m_axi_rready      = s_rready[grant_q];
        s_rdata           = m_axi_rdata;
        s_rlast           = m_axi_rlast;
        if (r_hs && m_axi_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Length checking only reports; the burst always ends on the downstream rlast.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q      <= REQ_ICACHE;
      last_grant_q <= REQ_DCACHE;
      lat_len_q    <= '0;
      beat_cnt_q   <= '0;
      len_err_q    <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      if (state_q == IDLE && pick_any) begin
        grant_q    <= pick_win;
        lat_len_q  <= s_arlen[pick_win];
        beat_cnt_q <= '0;
      end
      if (r_hs) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
        len_err_q  <= m_axi_rlast ? (beat_cnt_q != lat_len_q) : (beat_cnt_q == lat_len_q);
        if (m_axi_rlast) last_grant_q <= grant_q;
      end
    end
  end

  assign m_axi_arsize  = AR_SIZE;
  assign m_axi_arburst = AXI_BURST_WRAP;
  assign grant_idx     = grant_q;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays both caches and the downstream slave.
// Expected values are hand-derived per step.
module tb_axi_rd_arbiter;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       s_arvalid = '0;
  logic [1:0]       s_arready;
  logic [1:0][63:0] s_araddr = '0;
  logic [1:0][7:0]  s_arlen = '0;
  logic [1:0]       s_rvalid;
  logic [1:0]       s_rready = 2'b11;
  logic [63:0]      s_rdata;
  logic             s_rlast;
  logic             m_axi_arvalid;
  logic             m_axi_arready = 1'b0;
  logic [63:0]      m_axi_araddr;
  logic [7:0]       m_axi_arlen;
  logic [2:0]       m_axi_arsize;
  logic [1:0]       m_axi_arburst;
  logic             m_axi_rvalid = 1'b0;
  logic             m_axi_rready;
  logic [63:0]      m_axi_rdata = '0;
  logic             m_axi_rlast = 1'b0;
  logic             grant_idx;
  logic             len_err;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast), .grant_idx(grant_idx), .len_err(len_err)
  );

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int ar_hs_n = 0, rv0_n = 0, rv1_n = 0, lerr_n = 0;
  int rlast_cyc = 0, arv_cyc = 0;
  logic arv_prev = 1'b0;
  logic [63:0] rdq[$];
  int s_ar, s_rv0, s_rv1, s_lerr;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    arv_prev <= m_axi_arvalid;
    if (m_axi_arvalid && m_axi_arready) ar_hs_n <= ar_hs_n + 1;
    if (m_axi_arvalid && !arv_prev) arv_cyc <= cyc;
    if (m_axi_rvalid && m_axi_rready && m_axi_rlast) rlast_cyc <= cyc;
    if (s_rvalid[0] && s_rready[0]) rv0_n <= rv0_n + 1;
    if (s_rvalid[1] && s_rready[1]) begin
      rv1_n <= rv1_n + 1;
      rdq.push_back(s_rdata);
    end
    if (len_err) lerr_n <= lerr_n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_ar = ar_hs_n; s_rv0 = rv0_n; s_rv1 = rv1_n; s_lerr = lerr_n;
  endtask

  // Waits for the AR request, stalls arready for 'delay' cycles, then accepts it.
  task automatic ar_phase(input int delay, input logic exp_g, input logic [63:0] exp_addr);
    int n = 0;
    while (m_axi_arvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ar_wait", 64'(n < 20), 64'd1);
    chk("ar_grant", 64'(grant_idx), 64'(exp_g));
    chk("ar_addr", m_axi_araddr, exp_addr);
    repeat (delay) begin
      chk("ar_stall_rdy", 64'(s_arready), 64'd0);
      tick();
    end
    m_axi_arready = 1'b1;
    settle();
    chk("s_arready", 64'(s_arready), exp_g ? 64'd2 : 64'd1);
    tick();
    m_axi_arready = 1'b0;
  endtask

  task automatic r_beats(input int first, input int n, input int rlast_beat, input bit toggle,
                         input int base);
    for (int b = first; b < first + n; b++) begin
      int w = 0;
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 64'(base + b);
      m_axi_rlast  = (b == rlast_beat);
      settle();
      while (m_axi_rready !== 1'b1 && w < 10) begin
        if (toggle) chk("rready_mirror", 64'(m_axi_rready), 64'(s_rready[1]));
        tick();
        if (toggle) s_rready[1] = ~s_rready[1];
        settle();
        w++;
      end
      if (toggle) chk("rready_mirror", 64'(m_axi_rready), 64'(s_rready[1]));
      chk("r_wait", 64'(w < 10), 64'd1);
      tick();
      if (toggle) s_rready[1] = ~s_rready[1];
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  initial begin
    // Reset with live inputs: every handshake output must still read 0.
    s_araddr[0] = 64'h1000; s_araddr[1] = 64'h2000;
    s_arlen[0]  = 8'd7;     s_arlen[1]  = 8'd7;
    s_arvalid   = 2'b11;
    m_axi_rvalid = 1'b1;
    #12;
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_s_arready", 64'(s_arready), 64'd0);
    chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    chk("rst_araddr", m_axi_araddr, 64'd0);
    chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("arsize", 64'(m_axi_arsize), 64'd3);
    chk("arburst", 64'(m_axi_arburst), 64'd2);
    m_axi_rvalid = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Simultaneous requests: icache first, dcache AR two cycles after rlast.
    snap();
    ar_phase(0, 1'b0, 64'h1000);
    s_arvalid[0] = 1'b0;
    chk("tie_wait_rdy", 64'(s_arready), 64'd0);
    r_beats(0, 8, 7, 1'b0, 'hA0);
    chk("tie_rv0", 64'(rv0_n - s_rv0), 64'd8);
    chk("tie_rv1", 64'(rv1_n - s_rv1), 64'd0);
    ar_phase(0, 1'b1, 64'h2000);
    chk("rlast_gap", 64'(arv_cyc - rlast_cyc), 64'd2);
    s_arvalid[1] = 1'b0;
    r_beats(0, 8, 7, 1'b0, 'hB0);
    chk("tie_rv1_after", 64'(rv1_n - s_rv1), 64'd8);

    // Alternation with both requesters always asking.
    s_araddr[0] = 64'h100; s_araddr[1] = 64'h200;
    s_arlen[0]  = 8'd1;    s_arlen[1]  = 8'd1;
    s_arvalid   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ar_phase(0, 1'(k % 2), (k % 2) ? 64'h200 : 64'h100);
      chk("alt_wait_rdy", 64'(s_arready), 64'd0);
      r_beats(0, 2, 1, 1'b0, 'h10);
    end
    s_arvalid = 2'b00;

    // Single request with a slow slave.
    tick();
    snap();
    s_araddr[0] = 64'h8000_0040; s_arlen[0] = 8'd7;
    s_arvalid = 2'b01;
    settle();
    chk("arb_lat_idle", 64'(m_axi_arvalid), 64'd0);
    tick();
    chk("arb_lat_next", 64'(m_axi_arvalid), 64'd1);
    ar_phase(3, 1'b0, 64'h8000_0040);
    s_arvalid = 2'b00;
    r_beats(0, 8, 7, 1'b0, 'hC0);
    tick();
    chk("single_ar_cnt", 64'(ar_hs_n - s_ar), 64'd1);
    chk("single_rv0", 64'(rv0_n - s_rv0), 64'd8);
    chk("single_rv1", 64'(rv1_n - s_rv1), 64'd0);
    chk("single_len_err", 64'(lerr_n - s_lerr), 64'd0);

    // Backpressure from the dcache during a 4-beat burst.
    rdq.delete();
    snap();
    s_araddr[1] = 64'h3000; s_arlen[1] = 8'd3;
    s_arvalid = 2'b10;
    ar_phase(0, 1'b1, 64'h3000);
    s_arvalid = 2'b00;
    s_rready[1] = 1'b0;
    r_beats(0, 4, 3, 1'b1, 'hD0);
    s_rready = 2'b11;
    chk("bp_rv1", 64'(rv1_n - s_rv1), 64'd4);
    chk("bp_qsize", 64'(rdq.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("bp_data", rdq[i], 64'('hD0 + i));

    // Early rlast: arlen=3 but rlast on beat 1.
    tick();
    snap();
    s_araddr[0] = 64'h700; s_arlen[0] = 8'd3;
    s_arvalid = 2'b01;
    ar_phase(0, 1'b0, 64'h700);
    s_arvalid = 2'b00;
    r_beats(0, 2, 1, 1'b0, 'hE0);
    chk("early_len_err", 64'(len_err), 64'd1);
    tick();
    chk("early_pulse_end", 64'(len_err), 64'd0);
    chk("early_err_cnt", 64'(lerr_n - s_lerr), 64'd1);

    // Missing rlast: arlen=1, beat 1 without rlast, burst closed by rlast on beat 2.
    snap();
    s_arlen[0] = 8'd1;
    s_arvalid = 2'b01;
    ar_phase(0, 1'b0, 64'h700);
    s_arvalid = 2'b00;
    r_beats(0, 2, -1, 1'b0, 'hE8);
    chk("miss_len_err", 64'(len_err), 64'd1);
    chk("miss_err_cnt", 64'(lerr_n - s_lerr), 64'd0);
    r_beats(2, 1, 2, 1'b0, 'hE8);
    tick();
    // Second pulse comes from rlast arriving with beat_cnt=2 against arlen=1.
    chk("miss_err_total", 64'(lerr_n - s_lerr), 64'd2);

    // Reset mid-burst after the icache won last, then check the tie goes to icache again.
    s_araddr[0] = 64'h4000; s_arlen[0] = 8'd7;
    s_arvalid = 2'b01;
    ar_phase(0, 1'b0, 64'h4000);
    s_arvalid = 2'b00;
    r_beats(0, 2, 7, 1'b0, 'hF0);
    m_axi_rvalid = 1'b1;
    settle();
    chk("pre_rst_rvalid", 64'(s_rvalid), 64'd1);
    reset = 1'b0;
    settle();
    chk("mid_rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("mid_rst_rready", 64'(m_axi_rready), 64'd0);
    chk("mid_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("mid_rst_len_err", 64'(len_err), 64'd0);
    m_axi_rvalid = 1'b0;
    s_araddr[0] = 64'h5000; s_araddr[1] = 64'h6000;
    s_arvalid = 2'b11;
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_grant", 64'(grant_idx), 64'd0);
    chk("post_rst_addr", m_axi_araddr, 64'h5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
